// File: rtl/ex3_bcd_seq_ctrl.sv
// rtl/ex3_bcd_seq_ctrl.sv - packed excess-3 to packed BCD sequencer, one digit per clock, LSD first
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   in_valid      producer presents a word on in_data
//   in_ready      controller is idle and can take a word
//   in_data       excess-3 word, nibble k = digit k, nibble 0 = LSD
//   out_valid     out_data / out_err / out_err_mask are valid
//   out_ready     consumer takes the result
//   out_data      BCD word, same nibble ordering as in_data
//   out_err       any digit of the word was an invalid code
//   out_err_mask  bit k set when input digit k was an invalid code
//   busy          a word is being converted or waiting to be taken
module ex3_bcd_seq_ctrl #(
    parameter int DIGITS = 4,
    parameter int CW     = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_data,
    output logic                  out_err,
    output logic [DIGITS-1:0]     out_err_mask,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CW-1:0]         idx;
    logic [4*DIGITS-1:0]   operand;
    logic [4*DIGITS-1:0]   result;
    logic [DIGITS-1:0]     mask;

    logic [3:0]            cur_code;
    logic [3:0]            cur_bcd;
    logic                  cur_bad;
    logic                  last_digit;

    // Select the digit under conversion; a decoded mux keeps the index
    // arithmetic out of the part-select.
    always_comb begin
        cur_code = 4'h0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == CW'(k)) begin
                cur_code = operand[4*k +: 4];
            end
        end
    end

    // The single shared digit converter. Codes outside 3..12 become 4'hF.
    always_comb begin
        cur_bad = (cur_code < 4'd3) || (cur_code > 4'd12);
        cur_bcd = cur_bad ? 4'hF : (cur_code - 4'd3);
    end

    assign last_digit = (idx == CW'(DIGITS - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid)   state_nxt = CONV;
            CONV: if (last_digit) state_nxt = DONE;
            DONE: if (out_ready)  state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            operand <= '0;
            result  <= '0;
            mask    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        operand <= in_data;
                        result  <= '0;
                        mask    <= '0;
                        idx     <= '0;
                    end
                end
                CONV: begin
                    for (int k = 0; k < DIGITS; k++) begin
                        if (idx == CW'(k)) begin
                            result[4*k +: 4] <= cur_bcd;
                            mask[k]          <= cur_bad;
                        end
                    end
                    idx <= last_digit ? '0 : idx + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // All outputs decode registered state only; result and mask do not
    // change in DONE, so they stay stable under backpressure.
    assign in_ready     = (state == IDLE);
    assign busy         = (state != IDLE);
    assign out_valid    = (state == DONE);
    assign out_data     = result;
    assign out_err_mask = mask;
    assign out_err      = |mask;

endmodule

// File: tb/tb_ex3_bcd_seq_ctrl.sv
// tb/tb_ex3_bcd_seq_ctrl.sv - self-checking bench for ex3_bcd_seq_ctrl
module tb_ex3_bcd_seq_ctrl;

    localparam int DIGITS = 4;
    localparam int CW     = 3;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_err;
    logic [3:0]  out_err_mask;
    logic        busy;

    int checks = 0;
    int errors = 0;

    ex3_bcd_seq_ctrl #(.DIGITS(DIGITS), .CW(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_err      (out_err),
        .out_err_mask (out_err_mask),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] din;
        logic [15:0] dout;
        logic [3:0]  mask;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"},  32'(out_data), 32'h0);
        check({tag, "_out_err"},   32'(out_err), 32'd0);
        check({tag, "_out_mask"},  32'(out_err_mask), 32'h0);
        check({tag, "_busy"},      32'(busy), 32'd0);
        check({tag, "_in_ready"},  32'(in_ready), 32'd1);
    endtask

    // Waits for out_valid, counting edges since the last accept edge.
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // Starts #1 after an edge with the DUT idle; ends #1 after the handshake edge.
    task automatic run_txn(input logic [15:0] d, input logic [15:0] ed, input logic [3:0] em);
        int n;
        check("pre_in_ready", 32'(in_ready), 32'd1);
        in_data   = d;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("accept_busy", 32'(busy), 32'd1);
        wait_valid(n);
        check("latency", 32'(n), 32'(DIGITS));
        check("out_data", 32'(out_data), 32'(ed));
        check("out_mask", 32'(out_err_mask), 32'(em));
        check("out_err", 32'(out_err), 32'(em != 4'b0000));
        @(posedge clk); #1;
        check("post_out_valid", 32'(out_valid), 32'd0);
        check("post_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [15:0] held;

        vecs[0]  = '{16'h3C84, 16'h0951, 4'b0000};
        vecs[1]  = '{16'h3D40, 16'h0F1F, 4'b0101};
        vecs[2]  = '{16'h4567, 16'h1234, 4'b0000};
        vecs[3]  = '{16'hCCCC, 16'h9999, 4'b0000};
        vecs[4]  = '{16'h3330, 16'h000F, 4'b0001};
        vecs[5]  = '{16'h3331, 16'h000F, 4'b0001};
        vecs[6]  = '{16'h3332, 16'h000F, 4'b0001};
        vecs[7]  = '{16'h3333, 16'h0000, 4'b0000};
        vecs[8]  = '{16'h3334, 16'h0001, 4'b0000};
        vecs[9]  = '{16'h3335, 16'h0002, 4'b0000};
        vecs[10] = '{16'h3336, 16'h0003, 4'b0000};
        vecs[11] = '{16'h3337, 16'h0004, 4'b0000};
        vecs[12] = '{16'h3338, 16'h0005, 4'b0000};
        vecs[13] = '{16'h3339, 16'h0006, 4'b0000};
        vecs[14] = '{16'h333A, 16'h0007, 4'b0000};
        vecs[15] = '{16'h333B, 16'h0008, 4'b0000};
        vecs[16] = '{16'h333C, 16'h0009, 4'b0000};
        vecs[17] = '{16'h333D, 16'h000F, 4'b0001};
        vecs[18] = '{16'h333E, 16'h000F, 4'b0001};
        vecs[19] = '{16'h333F, 16'h000F, 4'b0001};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        out_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Table: basic words plus the digit-0 code sweep.
        for (int i = 0; i < 20; i++) begin
            run_txn(vecs[i].din, vecs[i].dout, vecs[i].mask);
        end

        // Backpressure: result held for 10 cycles, then one-cycle handshake.
        in_data   = 16'h4567;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(n);
        check("bp_latency", 32'(n), 32'(DIGITS));
        held = out_data;
        check("bp_data", 32'(held), 32'h1234);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("bp_valid_held", 32'(out_valid), 32'd1);
            check("bp_data_held", 32'(out_data), 32'h1234);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);

        // in_valid held with new data through CONV and DONE.
        in_data   = 16'h3C84;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_data = 16'h5555;
        wait_valid(n);
        check("hold_latency", 32'(n), 32'(DIGITS));
        for (int c = 0; c < 3; c++) begin
            check("hold_first_data", 32'(out_data), 32'h0951);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("hold_hs_valid", 32'(out_valid), 32'd0);
        check("hold_hs_idle", 32'(busy), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("hold_second_accept", 32'(busy), 32'd1);
        wait_valid(n);
        check("hold_second_latency", 32'(n), 32'(DIGITS));
        check("hold_second_data", 32'(out_data), 32'h2222);
        @(posedge clk); #1;
        check("hold_second_done", 32'(in_ready), 32'd1);

        // Reset during CONV after two digits aborts the word.
        in_data   = 16'h3C84;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_outputs("abort");
        n = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (out_valid) n++;
        end
        check("abort_no_valid", 32'(n), 32'd0);
        run_txn(16'h3333, 16'h0000, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
